// File: rtl/led_chaser_pkg.sv
// Shared types and width helper for the LED chaser and its button debouncers.
package led_chaser_pkg;

  typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dir_e;
  typedef enum logic {RUN = 1'b0, FLASH = 1'b1} state_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_width(input longint n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_chaser_if.sv
// Board-facing signals of the LED chaser: the two buttons, the LED drive and the status/debug view.
interface led_chaser_if
  import led_chaser_pkg::*;
#(
  parameter int N_LED   = 4,
  parameter int N_SPEED = 3
);
  localparam int POS_W = cnt_width(N_LED);
  localparam int SPD_W = cnt_width(N_SPEED + 1);

  logic               btn_dir;
  logic               btn_speed;
  logic [N_LED-1:0]   led;
  logic [POS_W-1:0]   pos;
  logic               dir;
  logic [SPD_W-1:0]   speed_lvl;
  state_e             state;

  modport master (
    input  btn_dir, btn_speed,
    output led, pos, dir, speed_lvl, state
  );

  modport slave (
    output btn_dir, btn_speed,
    input  led, pos, dir, speed_lvl, state
  );

endinterface

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-FF synchroniser, stability counter, one-cycle press pulse.
module btn_debounce
  import led_chaser_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  localparam int CW = cnt_width(DEBOUNCE_CYC);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      // A new level is accepted only after DEBOUNCE_CYC consecutive differing samples.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Walks one lit (active-low) LED across N_LED outputs; buttons toggle direction and cycle speed.
// Define LED_CHASER_BOUNCE_EN for ping-pong motion instead of wrap-around.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LED        = 4,
  parameter int STEP_BASE    = 25_000_000,
  parameter int N_SPEED      = 3,
  parameter int INIT_SPEED   = 2,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic          clk,
  input  logic          reset,
  led_chaser_if.master  bus
);
  localparam int POS_W = cnt_width(N_LED);
  localparam int SPD_W = cnt_width(N_SPEED + 1);
  localparam int TW    = cnt_width(longint'(STEP_BASE) * N_SPEED);
  localparam int PW    = cnt_width(longint'(STEP_BASE) * N_SPEED + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(N_SPEED);
  localparam logic [N_LED-1:0] LED_ONE  = {{(N_LED-1){1'b0}}, 1'b1};

  logic dir_ev;
  logic speed_ev;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dir (
    .clk   (clk),
    .reset (reset),
    .btn_n (bus.btn_dir),
    .press (dir_ev)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_speed (
    .clk   (clk),
    .reset (reset),
    .btn_n (bus.btn_speed),
    .press (speed_ev)
  );

  state_e           state_q, state_n;
  dir_e             dir_q, dir_n;
  logic [POS_W-1:0] pos_q, pos_n;
  logic [SPD_W-1:0] speed_q, speed_n;
  logic [TW-1:0]    timer_q, timer_n;
  logic [N_LED-1:0] led_q, led_n;
  logic [PW-1:0]    period;
  logic             term;

  // Full-width product so the largest step period never overflows the compare.
  assign period = PW'(STEP_BASE) * PW'(speed_q);
  assign term   = (PW'(timer_q) == period - PW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      dir_q   <= RIGHT;
      pos_q   <= '0;
      speed_q <= SPD_W'(INIT_SPEED);
      timer_q <= '0;
      led_q   <= '1;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      pos_q   <= pos_n;
      speed_q <= speed_n;
      timer_q <= timer_n;
      led_q   <= led_n;
    end
  end

  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    pos_n   = pos_q;
    speed_n = speed_q;
    timer_n = term ? '0 : timer_q + 1'b1;
    case (state_q)
      RUN: begin
        if (term) begin
`ifdef LED_CHASER_BOUNCE_EN
          if (dir_q == RIGHT) begin
            if (pos_q == POS_LAST) begin
              dir_n = LEFT;
              pos_n = pos_q - 1'b1;
            end else begin
              pos_n = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              dir_n = RIGHT;
              pos_n = pos_q + 1'b1;
            end else begin
              pos_n = pos_q - 1'b1;
            end
          end
`else
          if (dir_q == RIGHT) pos_n = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          else                pos_n = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
`endif
        end
        if (dir_ev) begin
          dir_n   = (dir_q == RIGHT) ? LEFT : RIGHT;
          pos_n   = pos_q;
          state_n = FLASH;
          timer_n = '0;
        end
      end
      FLASH: begin
        if (term) begin
          state_n = RUN;
          pos_n   = (dir_q == RIGHT) ? '0 : POS_LAST;
        end
      end
      default: state_n = RUN;
    endcase
    // A speed change restarts the current step or flash and never moves the LED.
    if (speed_ev) begin
      speed_n = (speed_q == SPD_MAX) ? SPD_W'(1) : speed_q + 1'b1;
      timer_n = '0;
      pos_n   = pos_q;
      if (state_q == FLASH) state_n = FLASH;
      if (!(state_q == RUN && dir_ev)) dir_n = dir_q;
    end
    led_n = (state_n == FLASH) ? '0 : ~(LED_ONE << pos_n);
  end

  assign bus.led       = led_q;
  assign bus.pos       = pos_q;
  assign bus.dir       = dir_q;
  assign bus.speed_lvl = speed_q;
  assign bus.state     = state_q;

endmodule
